// File: rtl/fifo_rd_pack.sv
// Packs RATIO show-ahead FIFO words into one wide output word with a single registered output slot.
// Optional idle auto-flush is built when FIFO_RD_PACK_TIMEOUT_EN is defined.
module fifo_rd_pack #(
    parameter int unsigned DSIZE = 8,
    parameter int unsigned RATIO = 4,
    parameter int unsigned TOUT  = 16
) (
    input  logic                       rd_clk,
    input  logic                       rd_rst,
    input  logic [DSIZE-1:0]           fifo_data,
    input  logic                       fifo_empty,
    output logic                       fifo_inc,
    input  logic                       flush,
    output logic [DSIZE*RATIO-1:0]     out_data,
    output logic [$clog2(RATIO):0]     out_cnt,
    output logic                       out_valid,
    input  logic                       out_ready
);

    localparam int unsigned OW = DSIZE * RATIO;
    localparam int unsigned CW = $clog2(RATIO) + 1;

    typedef enum logic [1:0] {
        ACC        = 2'd0,
        HOLD_FULL  = 2'd1,
        HOLD_FLUSH = 2'd2
    } state_t;

    if ((RATIO < 2) || ((RATIO & (RATIO - 1)) != 0) || (TOUT < 1)) begin : g_param_err
        $error("fifo_rd_pack: RATIO must be a power of two >= 2 and TOUT >= 1");
    end

    state_t          state_q, state_d;
    logic [OW-1:0]   acc_q, acc_d, acc_m;
    logic [CW-1:0]   pk_q, pk_d, pk_m;
    logic [CW-1:0]   fl_q, fl_d;
    logic [CW-1:0]   mv_cnt;
    logic [OW-1:0]   out_word;
    logic            move;
    logic            slot_free;
    logic            flush_eff;
    logic            tout_hit;

    assign slot_free = !out_valid || out_ready;
    assign flush_eff = flush || tout_hit;

`ifdef FIFO_RD_PACK_TIMEOUT_EN
    localparam int unsigned TW = $clog2(TOUT + 1);
    logic [TW-1:0] tcnt_q;

    assign tout_hit = (tcnt_q == TW'(TOUT));

    // Counts consecutive idle ACC cycles holding a partial word.
    always_ff @(posedge rd_clk) begin
        if (rd_rst) begin
            tcnt_q <= '0;
        end else if ((state_q == ACC) && (pk_q != '0) && !fifo_inc && !move && !tout_hit) begin
            tcnt_q <= tcnt_q + TW'(1);
        end else begin
            tcnt_q <= '0;
        end
    end
`else
    assign tout_hit = 1'b0;
`endif

    // Next-state, pop strobe and accumulator update.
    always_comb begin
        state_d  = state_q;
        fl_d     = fl_q;
        move     = 1'b0;
        mv_cnt   = pk_q;
        acc_m    = acc_q;
        pk_m     = pk_q;
        out_word = '0;

        case (state_q)
            ACC: begin
                if (flush_eff && (pk_q != '0)) begin
                    if (slot_free) begin
                        move = 1'b1;
                    end else begin
                        state_d = HOLD_FLUSH;
                        fl_d    = pk_q;
                    end
                end
            end
            HOLD_FULL: begin
                if (slot_free) begin
                    move = 1'b1;
                end
            end
            HOLD_FLUSH: begin
                if (slot_free) begin
                    move   = 1'b1;
                    mv_cnt = fl_q;
                end
            end
            default: state_d = ACC;
        endcase

        if (move) begin
            state_d = ACC;
        end

        fifo_inc = !rd_rst && !fifo_empty && ((state_q == ACC) || move);

        // A word popped while a flush was pending survives the move into lane 0.
        if (move) begin
            pk_m  = pk_q - mv_cnt;
            acc_m = '0;
            for (int unsigned i = 0; i < RATIO; i++) begin
                if (CW'(i) < mv_cnt) begin
                    out_word[i*DSIZE +: DSIZE] = acc_q[i*DSIZE +: DSIZE];
                end else if ((CW'(i) == mv_cnt) && (pk_q > mv_cnt)) begin
                    acc_m[DSIZE-1:0] = acc_q[i*DSIZE +: DSIZE];
                end
            end
        end

        acc_d = acc_m;
        pk_d  = pk_m;
        if (fifo_inc) begin
            for (int unsigned i = 0; i < RATIO; i++) begin
                if (CW'(i) == pk_m) begin
                    acc_d[i*DSIZE +: DSIZE] = fifo_data;
                end
            end
            pk_d = pk_m + CW'(1);
        end

        if ((state_d == ACC) && (pk_d == CW'(RATIO))) begin
            state_d = HOLD_FULL;
        end
    end

    always_ff @(posedge rd_clk) begin
        if (rd_rst) begin
            state_q   <= ACC;
            acc_q     <= '0;
            pk_q      <= '0;
            fl_q      <= '0;
            out_data  <= '0;
            out_cnt   <= '0;
            out_valid <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            pk_q    <= pk_d;
            fl_q    <= fl_d;
            if (move) begin
                out_data  <= out_word;
                out_cnt   <= mv_cnt;
                out_valid <= 1'b1;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule
